// File: rtl/posit_mul_seq.sv
// Multi-cycle posit<N,ES> multiplier: decode, shift-add mantissa multiply, RNE round, encode.
// Optional inexact/saturated status outputs are enabled by defining POSIT_MUL_STATUS_EN.
module posit_mul_seq #(
  parameter int N  = 32,
  parameter int ES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] posit_a,
  input  logic [N-1:0] posit_b,
  output logic         ready,
  output logic [N-1:0] posit_result,
  output logic         done
`ifdef POSIT_MUL_STATUS_EN
  ,
  output logic         inexact,
  output logic         saturated
`endif
);

  localparam int MW = N - ES - 2;
  localparam int SW = $clog2(N) + ES + 3;
  localparam int CW = $clog2(MW + 1);
  localparam int XW = ES + 2 * MW + 1;
  localparam int VW = XW + N;

  typedef enum logic [2:0] {StIdle, StDecode, StMul, StRound, StEncode} state_e;

  typedef struct packed {
    logic          zero;
    logic          nar;
    logic          sgn;
    logic [SW-1:0] scale;
    logic [MW-1:0] mant;
  } dec_t;

  function automatic dec_t decode(input logic [N-1:0] x);
    dec_t         d;
    logic [N-2:0] a;
    logic [N-2:0] rem;
    logic         run;
    int           m;
    int           k;
    int           e;
    d.sgn  = x[N-1];
    d.zero = (x == '0);
    d.nar  = (x == {1'b1, {(N-1){1'b0}}});
    a      = x[N-1] ? (~x[N-2:0] + 1'b1) : x[N-2:0];
    m      = 0;
    run    = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (a[i] == a[N-2])) m++;
      else run = 1'b0;
    end
    k = a[N-2] ? (m - 1) : -m;
    // Bits following the regime terminator, left-aligned: exponent then fraction.
    rem     = a << (m + 1);
    e       = int'(32'(rem) >> (N - 1 - ES));
    d.scale = SW'(k * (2 ** ES) + e);
    d.mant  = MW'({1'b1, rem[N-2-ES:0]} >> 2);
    return d;
  endfunction

  state_e               state_q;
  logic [N-1:0]         op_a_q, op_b_q;
  logic [MW-1:0]        ma_q;
  logic [2*MW-1:0]      p_q;
  logic [CW-1:0]        cnt_q;
  logic signed [SW-1:0] scale_q;
  logic                 sign_q, spec_q, spec_nar_q;
  logic [N-2:0]         mag_q;

  dec_t                 da, db;
  logic [MW:0]          addsum;
  logic [2*MW-1:0]      p_next;

  always_comb begin
    da     = decode(op_a_q);
    db     = decode(op_b_q);
    addsum = {1'b0, p_q[2*MW-1:MW]} + {1'b0, ma_q};
    p_next = p_q[0] ? {addsum, p_q[MW-1:1]} : {1'b0, p_q[2*MW-1:1]};
  end

  logic                 norm, k_over, k_under, guard, sticky, up, ovf;
  logic [2*MW-2:0]      frac;
  logic signed [SW-1:0] sc, k_s;
  logic [SW-1:0]        e_val;
  logic [XW-1:0]        x_str;
  logic signed [VW-1:0] v;
  logic [N-2:0]         body, rnd, mag;
  int                   k_int, sh;

  always_comb begin
    norm    = p_q[2*MW-1];
    frac    = norm ? p_q[2*MW-2:0] : {p_q[2*MW-3:0], 1'b0};
    sc      = scale_q + $signed({{(SW-1){1'b0}}, norm});
    k_s     = sc >>> ES;
    e_val   = sc & SW'((1 << ES) - 1);
    k_int   = int'(k_s);
    k_over  = (k_int > N - 2);
    k_under = (k_int < -(N - 1));
    sh      = (k_int >= 0) ? k_int : (-k_int - 1);
    if (sh > N) sh = N;
    // "10" smeared right gives k+1 ones then 0; "01" gives -k zeros then 1.
    x_str   = (XW'(k_s < 0 ? 2'b01 : 2'b10) << (XW - 2)) | (XW'(e_val) << (2 * MW - 1))
              | XW'(frac);
    v       = $signed({x_str, {N{1'b0}}}) >>> sh;
    body    = v[VW-1:VW-N+1];
    guard   = v[VW-N];
    sticky  = |v[VW-N-1:0];
    up      = guard & (sticky | body[0]);
    {ovf, rnd} = {1'b0, body} + N'(up);
    if (k_over || ovf)             mag = '1;
    else if (k_under || rnd == '0) mag = {{(N-2){1'b0}}, 1'b1};
    else                           mag = rnd;
  end

`ifdef POSIT_MUL_STATUS_EN
  logic inx, sat, inx_q, sat_q;
  always_comb begin
    inx = guard | sticky | k_over | k_under;
    sat = k_over | k_under | (body == '0) | ((&body) & (guard | sticky));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      ready        <= 1'b1;
      done         <= 1'b0;
      posit_result <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      ma_q         <= '0;
      p_q          <= '0;
      cnt_q        <= '0;
      scale_q      <= '0;
      sign_q       <= 1'b0;
      spec_q       <= 1'b0;
      spec_nar_q   <= 1'b0;
      mag_q        <= '0;
`ifdef POSIT_MUL_STATUS_EN
      inx_q        <= 1'b0;
      sat_q        <= 1'b0;
      inexact      <= 1'b0;
      saturated    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            op_a_q  <= posit_a;
            op_b_q  <= posit_b;
            ready   <= 1'b0;
            state_q <= StDecode;
          end
        end
        StDecode: begin
          sign_q     <= da.sgn ^ db.sgn;
          scale_q    <= $signed(da.scale) + $signed(db.scale);
          ma_q       <= da.mant;
          p_q        <= {{MW{1'b0}}, db.mant};
          cnt_q      <= '0;
          spec_nar_q <= da.nar | db.nar;
          spec_q     <= da.nar | db.nar | da.zero | db.zero;
          state_q    <= (da.nar | db.nar | da.zero | db.zero) ? StEncode : StMul;
        end
        StMul: begin
          p_q   <= p_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(MW - 1)) state_q <= StRound;
        end
        StRound: begin
          mag_q   <= mag;
`ifdef POSIT_MUL_STATUS_EN
          inx_q   <= inx;
          sat_q   <= sat;
`endif
          state_q <= StEncode;
        end
        StEncode: begin
          if (spec_q) posit_result <= spec_nar_q ? {1'b1, {(N-1){1'b0}}} : '0;
          else        posit_result <= sign_q ? (~{1'b0, mag_q} + 1'b1) : {1'b0, mag_q};
`ifdef POSIT_MUL_STATUS_EN
          inexact   <= ~spec_q & inx_q;
          saturated <= ~spec_q & sat_q;
`endif
          done    <= 1'b1;
          ready   <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_posit_mul_seq.sv
// Bench for posit_mul_seq: directed posit<32,3> cases plus random posit<16,1> against a
// value-level reference model (decode to real, multiply, pick nearest posit by bit-string RNE).
module tb_posit_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start16;
  logic [31:0] a32, b32, res32;
  logic [15:0] a16, b16, res16;
  logic        ready32, done32, ready16, done16;
`ifdef POSIT_MUL_STATUS_EN
  logic        inx32, sat32, inx16, sat16;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  posit_mul_seq #(.N(32), .ES(3)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .posit_a(a32), .posit_b(b32),
    .ready(ready32), .posit_result(res32), .done(done32)
`ifdef POSIT_MUL_STATUS_EN
    , .inexact(inx32), .saturated(sat32)
`endif
  );

  posit_mul_seq #(.N(16), .ES(1)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .posit_a(a16), .posit_b(b16),
    .ready(ready16), .posit_result(res16), .done(done16)
`ifdef POSIT_MUL_STATUS_EN
    , .inexact(inx16), .saturated(sat16)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic real pow2(input int x);
    real r;
    r = 1.0;
    if (x >= 0) repeat (x) r = r * 2.0;
    else repeat (-x) r = r / 2.0;
    return r;
  endfunction

  // Value of a positive n-bit posit pattern (sign bit clear, nonzero).
  function automatic real pval(input logic [63:0] bits, input int n, input int es);
    int  i, m, k, e;
    logic r;
    real f, w;
    i = n - 2;
    r = bits[n-2];
    m = 0;
    while (i >= 0 && bits[i] == r) begin
      m++;
      i--;
    end
    k = r ? m - 1 : -m;
    i--;
    e = 0;
    for (int j = 0; j < es; j++) begin
      e = e * 2;
      if (i >= 0) begin
        e = e + int'(bits[i]);
        i--;
      end
    end
    f = 1.0;
    w = 0.5;
    while (i >= 0) begin
      if (bits[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    return pow2(k * (1 << es) + e) * f;
  endfunction

  function automatic logic [15:0] ref16(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] ma, mb, p, lo, hi, mid;
    real         v, t;
    if (a == 16'h8000 || b == 16'h8000) return 16'h8000;
    if (a == 16'h0000 || b == 16'h0000) return 16'h0000;
    ma = a[15] ? 16'(-a) : a;
    mb = b[15] ? 16'(-b) : b;
    v  = pval(64'(ma), 16, 1) * pval(64'(mb), 16, 1);
    if (v >= pval(64'h7FFF, 16, 1)) p = 16'h7FFF;
    else if (v <= pval(64'h0001, 16, 1)) p = 16'h0001;
    else begin
      lo = 16'h0001;
      hi = 16'h7FFF;
      while (hi - lo > 1) begin
        mid = (lo + hi) / 2;
        if (pval(64'(mid), 16, 1) <= v) lo = mid;
        else hi = mid;
      end
      p = lo;
      if (v != pval(64'(p), 16, 1)) begin
        // Tie point between p and p+1 is the (N+1)-bit posit that extends p with a 1.
        t = pval({47'b0, p, 1'b1}, 17, 1);
        if (v > t) p = p + 1;
        else if (v == t && p[0]) p = p + 1;
      end
    end
    return (a[15] ^ b[15]) ? 16'(-p) : p;
  endfunction

  task automatic run_op(input bit w16, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    int cyc;
    cyc = 0;
    while (!(w16 ? ready16 : ready32) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " ready_before"}, {31'b0, (w16 ? ready16 : ready32)}, 32'd1);
    @(negedge clk);
    if (w16) begin
      start16 = 1'b1;
      a16 = a[15:0];
      b16 = b[15:0];
    end else begin
      start32 = 1'b1;
      a32 = a;
      b32 = b;
    end
    @(posedge clk);
    #1;
    start16 = 1'b0;
    start32 = 1'b0;
    cyc = 0;
    while (!(w16 ? done16 : done32) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'(lat));
    check({tag, " result"}, w16 ? {16'b0, res16} : res32, exp);
    check({tag, " ready_in_done"}, {31'b0, (w16 ? ready16 : ready32)}, 32'd1);
  endtask

  initial begin
    int          acc, idx2, cyc;
    logic        d2, saw_done;
    logic [15:0] ra, rb;
    rst = 1'b1;
    start32 = 1'b0;
    start16 = 1'b0;
    a32 = '0;
    b32 = '0;
    a16 = '0;
    b16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ready", {31'b0, ready32}, 32'd1);
    check("reset done", {31'b0, done32}, 32'd0);
    check("reset result", res32, 32'h0);
    check("reset result16", {16'b0, res16}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(1'b0, 32'h40000000, 32'h40000000, 32'h40000000, 30, "1x1");
    run_op(1'b0, 32'h42000000, 32'h42000000, 32'h44800000, 30, "1.5x1.5");
    run_op(1'b0, 32'h44000000, 32'h44000000, 32'h48000000, 30, "2x2");
    run_op(1'b0, 32'hC0000000, 32'h44000000, 32'hBC000000, 30, "-1x2");
    run_op(1'b0, 32'hC0000000, 32'hC0000000, 32'h40000000, 30, "-1x-1");
    run_op(1'b0, 32'h80000000, 32'h00000000, 32'h80000000, 2, "nar_x_0");
    run_op(1'b0, 32'h00000000, 32'h40000000, 32'h00000000, 2, "0x1");
    run_op(1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 30, "maxpos_sq");
    run_op(1'b0, 32'h00000001, 32'h00000001, 32'h00000001, 30, "minpos_sq");
    run_op(1'b0, 32'h80000001, 32'h7FFFFFFF, 32'h80000001, 30, "negmax_x_max");

    // start held high while busy: second accept must land in the done cycle
    @(negedge clk);
    start32 = 1'b1;
    a32 = 32'h44000000;
    b32 = 32'h42000000;
    acc = 0;
    idx2 = -1;
    d2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (ready32) begin
        acc++;
        if (acc == 2) begin
          idx2 = i;
          d2 = done32;
        end
      end
    end
    start32 = 1'b0;
    check("hold accepts", 32'(acc), 32'd2);
    check("hold second_idx", 32'(idx2), 32'd31);
    check("hold done_at_accept", {31'b0, d2}, 32'd1);
    check("hold first_result", res32, 32'h46000000);
    cyc = 0;
    while (!done32 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("hold second_result", res32, 32'h46000000);
    check("hold second_done", {31'b0, done32}, 32'd1);

    // reset mid-operation aborts it
    @(negedge clk);
    start32 = 1'b1;
    a32 = 32'h44000000;
    b32 = 32'h44000000;
    @(posedge clk);
    #1;
    start32 = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort ready", {31'b0, ready32}, 32'd1);
    check("abort done", {31'b0, done32}, 32'd0);
    check("abort result", res32, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32) saw_done = 1'b1;
    end
    check("abort no_done", {31'b0, saw_done}, 32'd0);

    run_op(1'b1, 32'h4000, 32'h6000, 32'h6000, 16, "n16 1x4");
    check("n16 model 1x4", {16'b0, ref16(16'h4000, 16'h6000)}, 32'h6000);
    for (int i = 0; i < 80; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 15) == 0) ra = 16'h8000;
      if ($urandom_range(0, 15) == 0) rb = 16'h0000;
      run_op(1'b1, {16'b0, ra}, {16'b0, rb}, {16'b0, ref16(ra, rb)},
             (ra == 16'h0000 || rb == 16'h0000 || ra == 16'h8000 || rb == 16'h8000) ? 2 : 16,
             $sformatf("n16 rand %0d %h*%h", i, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
